// File: rtl/riscv_hazard_ctrl_pkg.sv
// Shared constants for the hazard controller: register index type, the
// opcode field values it decodes and the wait-FSM encodings.
package riscv_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // inst[6:2] values
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_OPIMM = 5'b00100;
  localparam logic [4:0] OP_LOAD  = 5'b00000;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/riscv_src_use.sv
// Opcode -> source-register usage decode; shared with the forwarding unit
// so both agree on when rs2 is a real operand.
module riscv_src_use
  import riscv_hazard_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       uses_rs1,
  output logic       uses_rs2
);

  logic no_src;
  logic rs1_only;

  assign no_src   = (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL);
  assign rs1_only = (opcode == OP_OPIMM) || (opcode == OP_LOAD) || (opcode == OP_JALR);

  assign uses_rs1 = !no_src;
  assign uses_rs2 = !no_src && !rs1_only;

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Stall/flush/redirect controller for the 5-stage pipeline: load-use
// bubbles, taken-branch squashes and data-memory freezes with a timeout.
//
// state | meaning
// RUN   | no memory access stalled
// WAIT  | MEM stage waiting on dmem_ready; wait counter running
module riscv_hazard_ctrl
  import riscv_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IF_ID_opcode,
  input  reg_addr_t   IF_ID_rs1_idx,
  input  reg_addr_t   IF_ID_rs2_idx,
  input  logic        ID_EX_MemtoReg,
  input  logic        ID_EX_RegWr,
  input  reg_addr_t   ID_EX_rd_idx,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_stall,
  output logic        IF_ID_stall,
  output logic        ID_EX_stall,
  output logic        EX_MEM_stall,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        MEM_WB_flush,
  output logic        pc_redirect,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  logic [0:0] state;
  logic       pend_br;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       freeze;
  logic       br;
  logic       lu;
  logic       lu_hit;
  logic       load_use;
  logic       active;

  riscv_src_use u_src_use (
    .opcode   (IF_ID_opcode),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign freeze = dmem_req && !dmem_ready;
  assign br     = (branch_taken || pend_br) && !freeze;
  assign lu     = ID_EX_MemtoReg && ID_EX_RegWr && (ID_EX_rd_idx != '0);
  assign lu_hit = lu && ((uses_rs1 && (ID_EX_rd_idx == IF_ID_rs1_idx)) ||
                         (uses_rs2 && (ID_EX_rd_idx == IF_ID_rs2_idx)));
  // A squashed ID instruction cannot cause a load-use bubble.
  assign load_use = lu_hit && !freeze && !br;

  // Gate with rst so the controls fall the moment reset is applied.
  assign active       = !rst;
  assign pc_stall     = active && (freeze || load_use);
  assign IF_ID_stall  = active && (freeze || load_use);
  assign ID_EX_stall  = active && freeze;
  assign EX_MEM_stall = active && freeze;
  assign MEM_WB_flush = active && freeze;
  assign IF_ID_flush  = active && br;
  assign ID_EX_flush  = active && (br || load_use);
  assign pc_redirect  = active && br;

  assign wait_nxt = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      pend_br   <= 1'b0;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (state == ST_RUN) begin
        if (freeze) begin
          state    <= ST_WAIT;
          wait_cnt <= '0;
        end
      end else begin
        if (dmem_ready || !dmem_req) state <= ST_RUN;
        wait_cnt <= wait_nxt;
        if (wait_nxt == TIMEOUT) mem_err <= 1'b1;
      end

      if (br) pend_br <= 1'b0;
      else if (branch_taken && freeze) pend_br <= 1'b1;

      if (pc_stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Directed bench for riscv_hazard_ctrl with MEM_TIMEOUT = 4.
module tb_riscv_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  IF_ID_opcode;
  logic [4:0]  IF_ID_rs1_idx;
  logic [4:0]  IF_ID_rs2_idx;
  logic        ID_EX_MemtoReg;
  logic        ID_EX_RegWr;
  logic [4:0]  ID_EX_rd_idx;
  logic        branch_taken;
  logic        dmem_req;
  logic        dmem_ready;
  logic        pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall;
  logic        IF_ID_flush, ID_EX_flush, MEM_WB_flush, pc_redirect;
  logic        mem_err;
  logic [15:0] stall_cnt;
  logic [7:0]  ctl;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] OPC_OP    = 5'b01100;
  localparam logic [4:0] OPC_LUI   = 5'b01101;
  localparam logic [4:0] OPC_OPIMM = 5'b00100;

  // {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, IF_ID_flush, ID_EX_flush, MEM_WB_flush, pc_redirect}
  localparam logic [7:0] C_NONE   = 8'h00;
  localparam logic [7:0] C_FREEZE = 8'hF2;
  localparam logic [7:0] C_LU     = 8'hC4;
  localparam logic [7:0] C_BR     = 8'h0D;

  riscv_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .IF_ID_opcode   (IF_ID_opcode),
    .IF_ID_rs1_idx  (IF_ID_rs1_idx),
    .IF_ID_rs2_idx  (IF_ID_rs2_idx),
    .ID_EX_MemtoReg (ID_EX_MemtoReg),
    .ID_EX_RegWr    (ID_EX_RegWr),
    .ID_EX_rd_idx   (ID_EX_rd_idx),
    .branch_taken   (branch_taken),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .pc_stall       (pc_stall),
    .IF_ID_stall    (IF_ID_stall),
    .ID_EX_stall    (ID_EX_stall),
    .EX_MEM_stall   (EX_MEM_stall),
    .IF_ID_flush    (IF_ID_flush),
    .ID_EX_flush    (ID_EX_flush),
    .MEM_WB_flush   (MEM_WB_flush),
    .pc_redirect    (pc_redirect),
    .mem_err        (mem_err),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
                IF_ID_flush, ID_EX_flush, MEM_WB_flush, pc_redirect};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    IF_ID_opcode   = OPC_OP;
    IF_ID_rs1_idx  = 5'd0;
    IF_ID_rs2_idx  = 5'd0;
    ID_EX_MemtoReg = 1'b0;
    ID_EX_RegWr    = 1'b0;
    ID_EX_rd_idx   = 5'd0;
    branch_taken   = 1'b0;
    dmem_req       = 1'b0;
    dmem_ready     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic set_id(input logic [4:0] opc, input logic [4:0] rs1, input logic [4:0] rs2);
    IF_ID_opcode  = opc;
    IF_ID_rs1_idx = rs1;
    IF_ID_rs2_idx = rs2;
  endtask

  task automatic set_ex_load(input logic [4:0] rd);
    ID_EX_MemtoReg = 1'b1;
    ID_EX_RegWr    = 1'b1;
    ID_EX_rd_idx   = rd;
  endtask

  initial begin
    // Reset held while every hazard input is active: outputs must stay low.
    rst = 1'b1;
    idle_inputs();
    set_ex_load(5'd5);
    set_id(OPC_OP, 5'd5, 5'd7);
    dmem_req = 1'b1;
    branch_taken = 1'b1;
    #12;
    chk("reset_ctl", {8'h0, ctl}, {8'h0, C_NONE});
    chk("reset_stall_cnt", stall_cnt, 16'd0);
    chk("reset_mem_err", {15'd0, mem_err}, 16'd0);
    do_reset();

    // Load-use hit: lw x5 in EX, add x6,x5,x7 in ID.
    set_ex_load(5'd5);
    set_id(OPC_OP, 5'd5, 5'd7);
    #1;
    chk("lu_hit_ctl", {8'h0, ctl}, {8'h0, C_LU});
    tick();
    ID_EX_MemtoReg = 1'b0;
    ID_EX_RegWr    = 1'b0;
    ID_EX_rd_idx   = 5'd0;
    #1;
    chk("lu_bubble_ctl", {8'h0, ctl}, {8'h0, C_NONE});
    chk("lu_stall_cnt", stall_cnt, 16'd1);

    // Filtered cases.
    set_ex_load(5'd5);
    set_id(OPC_LUI, 5'd5, 5'd5);
    #1;
    chk("lu_lui_ctl", {8'h0, ctl}, {8'h0, C_NONE});
    set_ex_load(5'd0);
    set_id(OPC_OP, 5'd0, 5'd0);
    #1;
    chk("lu_x0_ctl", {8'h0, ctl}, {8'h0, C_NONE});
    set_ex_load(5'd5);
    set_id(OPC_OPIMM, 5'd2, 5'd5);
    #1;
    chk("lu_addi_rs2_ctl", {8'h0, ctl}, {8'h0, C_NONE});
    set_id(OPC_OP, 5'd7, 5'd5);
    #1;
    chk("lu_rs2_hit_ctl", {8'h0, ctl}, {8'h0, C_LU});
    ID_EX_RegWr = 1'b0;
    #1;
    chk("lu_no_regwr_ctl", {8'h0, ctl}, {8'h0, C_NONE});
    do_reset();

    // Branch squash overrides a simultaneous load-use.
    set_ex_load(5'd5);
    set_id(OPC_OP, 5'd5, 5'd7);
    branch_taken = 1'b1;
    #1;
    chk("br_ctl", {8'h0, ctl}, {8'h0, C_BR});
    tick();
    chk("br_stall_cnt", stall_cnt, 16'd0);
    idle_inputs();
    #1;
    chk("br_after_ctl", {8'h0, ctl}, {8'h0, C_NONE});
    do_reset();

    // Freeze for 3 cycles with a branch pulse in the first.
    dmem_req = 1'b1;
    dmem_ready = 1'b0;
    branch_taken = 1'b1;
    #1;
    chk("frz_c1_ctl", {8'h0, ctl}, {8'h0, C_FREEZE});
    tick();
    branch_taken = 1'b0;
    #1;
    chk("frz_c2_ctl", {8'h0, ctl}, {8'h0, C_FREEZE});
    tick();
    chk("frz_c3_ctl", {8'h0, ctl}, {8'h0, C_FREEZE});
    tick();
    dmem_ready = 1'b1;
    #1;
    chk("frz_c4_ctl", {8'h0, ctl}, {8'h0, C_BR});
    chk("frz_stall_cnt", stall_cnt, 16'd3);
    tick();
    dmem_req = 1'b0;
    dmem_ready = 1'b0;
    #1;
    chk("frz_c5_ctl", {8'h0, ctl}, {8'h0, C_NONE});
    chk("frz_mem_err", {15'd0, mem_err}, 16'd0);
    do_reset();

    // Timeout: entry edge plus four WAIT cycles.
    dmem_req = 1'b1;
    dmem_ready = 1'b0;
    repeat (4) tick();
    chk("to_before", {15'd0, mem_err}, 16'd0);
    tick();
    chk("to_set", {15'd0, mem_err}, 16'd1);
    dmem_ready = 1'b1;
    tick();
    dmem_req = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) tick();
    chk("to_sticky", {15'd0, mem_err}, 16'd1);
    chk("to_stall_cnt", stall_cnt, 16'd5);

    // Asynchronous reset in the middle of WAIT.
    dmem_req = 1'b1;
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ctl", {8'h0, ctl}, {8'h0, C_NONE});
    chk("arst_stall_cnt", stall_cnt, 16'd0);
    chk("arst_mem_err", {15'd0, mem_err}, 16'd0);
    dmem_req = 1'b0;
    #1;
    rst = 1'b0;
    tick();
    chk("arst_post_ctl", {8'h0, ctl}, {8'h0, C_NONE});
    chk("arst_post_cnt", stall_cnt, 16'd0);
    // From RUN, a fresh freeze needs the full five edges to time out.
    dmem_req = 1'b1;
    repeat (4) tick();
    chk("arst_wait_cleared", {15'd0, mem_err}, 16'd0);
    dmem_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_hazard_ctrl.md
# riscv_hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It produces the hold and bubble controls for every pipeline register and the PC. It covers the cases the forwarding unit cannot resolve: load-use dependencies, taken-branch squashes and data-memory wait states. It sits beside `riscv_forward` in the core top level and drives the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB register enables.

## Interface
- `MEM_TIMEOUT`, default 255: maximum data-memory wait cycles before `mem_err` sets; range 1..255.
- `clk` input 1: single core clock; all state is updated on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `IF_ID_opcode` input 5: inst[6:2] of the instruction in ID.
- `IF_ID_rs1_idx`, `IF_ID_rs2_idx` input `RegAddrBus`: source indices in ID.
- `ID_EX_MemtoReg`, `ID_EX_RegWr` input 1: the instruction in EX is a load / writes a register.
- `ID_EX_rd_idx` input `RegAddrBus`: destination of the instruction in EX.
- `branch_taken` input 1: branch/jump in EX resolved taken.
- `dmem_req` input 1: MEM stage has an access outstanding.
- `dmem_ready` input 1: data memory completes the access this cycle.
- `pc_stall`, `IF_ID_stall`, `ID_EX_stall`, `EX_MEM_stall` output 1: hold the register.
- `IF_ID_flush`, `ID_EX_flush`, `MEM_WB_flush` output 1: load a bubble (all control bits zero).
- `pc_redirect` output 1: PC loads the branch target this edge.
- `mem_err` output 1: sticky; memory wait exceeded `MEM_TIMEOUT`.
- `stall_cnt` output 16: saturating count of stall cycles.

## Operation
- **rs1/rs2 usage decode** (from `IF_ID_opcode`):
  - LUI, AUIPC and JAL use neither source.
  - OP-IMM, LOAD and JALR use rs1 only.
  - All other opcodes use both sources.
- **Load-use hazard, combinational:**
  - Condition: `lu = ID_EX_MemtoReg & ID_EX_RegWr & (ID_EX_rd_idx != 0)`, and `ID_EX_rd_idx` matches a used source in ID.
  - Response: `pc_stall`, `IF_ID_stall` and `ID_EX_flush` for exactly one cycle.
  - The inserted bubble clears the condition on the next cycle.
- **Memory freeze, combinational:**
  - Condition: `freeze = dmem_req & ~dmem_ready`.
  - Response: `pc_stall`, `IF_ID_stall`, `ID_EX_stall`, `EX_MEM_stall` and `MEM_WB_flush`.
  - While frozen, all other flushes and `pc_redirect` are forced to 0.
- **Branch squash:**
  - Condition: `br = (branch_taken | pend_br) & ~freeze`.
  - Response: `pc_redirect`, `IF_ID_flush` and `ID_EX_flush`.
  - Any load-use stall in the same cycle is discarded, because the ID instruction is squashed.
- **Priority:** freeze > branch > load-use.
- **FSM states:** RUN, WAIT.
  - RUN → WAIT when `freeze`.
  - WAIT → RUN when `dmem_ready`, or when `dmem_req` drops.
- **`pend_br` register:**
  - Set when `branch_taken & freeze`.
  - Cleared on the cycle `br` is asserted.
  - A taken branch seen during a freeze therefore redirects on the first unfrozen cycle, even if `branch_taken` has dropped.
- **Wait counter (8 bits):**
  - Clears on entry to WAIT, increments each WAIT cycle.
  - When it equals `MEM_TIMEOUT`, `mem_err` sets and stays set until `rst`. The FSM keeps waiting.
- **`stall_cnt`:** increments on any cycle where `pc_stall` = 1 and saturates at 16'hFFFF.

## Timing
- **Reset values:** all outputs 0, state RUN, `pend_br` = 0, wait counter = 0, `stall_cnt` = 0.
- Stall, flush and redirect outputs are combinational from the inputs and the registered state, with zero-cycle latency.
- Load-use costs 1 bubble. A taken branch costs 2 squashed slots.
- A freeze lasts exactly the cycles where `dmem_ready` = 0. With `dmem_req` = `dmem_ready` = 1 in the same cycle, there is no stall.
- **Reset mid-WAIT:** state returns to RUN, `pend_br` and the counters clear, and outputs drop to 0 asynchronously.

## Structure
- `riscv_define.v` holds the opcode constants (OP_LUI 01101, OP_AUIPC 00101, OP_JAL 11011, OP_JALR 11001, OP_OPIMM 00100, OP_LOAD 00000) and the state encodings.
- One sub-module, `riscv_src_use`: a combinational opcode → {uses_rs1, uses_rs2} decoder, reused by `riscv_forward` for its rs2 qualification.

## Test plan
- **Load-use hit:** lw x5 in EX (MemtoReg = 1, rd = 5), add x6,x5,x7 in ID → `pc_stall` = `IF_ID_stall` = `ID_EX_flush` = 1 for one cycle, then 0; `stall_cnt` = 1.
- **Load-use filtered:**
  - lw x5 with lui x5 in ID → no stall.
  - lw x0 with add x1,x0,x0 in ID → no stall.
  - addi x1,x2,5 in ID, where rs2 field = 5, after lw x5 → no stall.
- **Branch squash:** `branch_taken` = 1 for one cycle, with a load-use condition also true → `pc_redirect` = `IF_ID_flush` = `ID_EX_flush` = 1, `pc_stall` = 0.
- **Freeze with deferred branch:**
  - Stimulus: `dmem_req` = 1, `dmem_ready` = 0 for 3 cycles; `branch_taken` pulses in cycle 1.
  - Response: 3 cycles of full stall with `MEM_WB_flush` and no redirect.
  - Cycle 4 (`dmem_ready` = 1): `pc_redirect` = 1; `stall_cnt` = 3.
- **Timeout:** `MEM_TIMEOUT` = 4, `dmem_ready` held 0 → `mem_err` rises after the 4th WAIT cycle and stays 1 after `dmem_ready`; only `rst` clears it.
- **Async reset mid-WAIT:** assert `rst` between edges → all outputs 0 immediately; after release the FSM is in RUN with `stall_cnt` = 0.
